rif_csr_bank: RTL and testbench

- Register-file target for the RIF side of the AXI4-Lite adapter.
- Consumes the adapter's rif_waddr/rif_wr_req/rif_wstrb/rif_wdata and rif_raddr/rif_rd_req.
- Returns same-cycle rif_wvalid/rif_rvalid/rif_rdata.
- Holds ID, control, interrupt (status W1C / enable / force) and general-purpose registers, and drives a registered level interrupt.

---
 rtl/rif_csr_pkg.sv | 30 +++
 rtl/rif_csr_irq.sv | 52 +++++
 rtl/rif_csr_bank.sv | 142 ++++++++++++++
 tb/tb_rif_csr_bank.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rif_csr_pkg.sv
// rtl/rif_csr_pkg.sv - word map, access types and strobe helper for the RIF CSR bank
// Contents: word-index localparams, acc_e access-type enum, strb_to_mask().
package rif_csr_pkg;

    localparam int IDX_ID         = 0;
    localparam int IDX_CTRL       = 1;
    localparam int IDX_IRQ_STATUS = 2;
    localparam int IDX_IRQ_ENABLE = 3;
    localparam int IDX_IRQ_FORCE  = 4;
    localparam int IDX_CYCLE      = 5;
    localparam int IDX_GP_BASE    = 8;

    typedef enum logic [2:0] {
        ACC_NONE,
        ACC_RO,
        ACC_RW,
        ACC_W1C,
        ACC_WO
    } acc_e;

    // Each strobe bit covers one byte lane of the 32-bit word.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rif_csr_irq.sv
// rtl/rif_csr_irq.sv - interrupt status/enable storage and registered level interrupt
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   status_wr/enable_wr/force_wr  decoded, valid write to the matching register
//   wbits                      write data already ANDed with the byte mask
//   wmask_bits                 byte mask restricted to the interrupt bits
//   irq_event_i                hardware set sources
//   status_o, enable_o         current register values
//   irq_o                      registered OR of enabled pending status
module rif_csr_irq #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               status_wr,
    input  logic               enable_wr,
    input  logic               force_wr,
    input  logic [NUM_IRQ-1:0] wbits,
    input  logic [NUM_IRQ-1:0] wmask_bits,
    input  logic [NUM_IRQ-1:0] irq_event_i,
    output logic [NUM_IRQ-1:0] status_o,
    output logic [NUM_IRQ-1:0] enable_o,
    output logic               irq_o
);

    logic [NUM_IRQ-1:0] status_q, enable_q;
    logic [NUM_IRQ-1:0] w1c_clear, force_set, status_next;

    assign w1c_clear = status_wr ? wbits : '0;
    assign force_set = force_wr  ? wbits : '0;
    // Sets are ORed in after the clear so a hardware event beats a W1C of the same bit.
    assign status_next = (status_q & ~w1c_clear) | irq_event_i | force_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q <= '0;
            enable_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            status_q <= status_next;
            if (enable_wr) begin
                enable_q <= (enable_q & ~wmask_bits) | wbits;
            end
            // Looks at the registered status, so irq_o trails the status update by one edge.
            irq_o <= |(status_q & enable_q);
        end
    end

    assign status_o = status_q;
    assign enable_o = enable_q;

endmodule

// File: rtl/rif_csr_bank.sv
// rtl/rif_csr_bank.sv - RIF register-file target: ID, CTRL, IRQ and GP registers
// Optional: define RIF_CSR_CYCLE_COUNTER_EN to map a free-running RO counter at word 5.
// Ports:
//   clk, reset                            clock, asynchronous active-high reset
//   rif_waddr/rif_wr_req/rif_wstrb/rif_wdata  write request
//   rif_wvalid                            write hits a writable register (comb)
//   rif_raddr/rif_rd_req                  read request
//   rif_rvalid/rif_rdata                  read hit and data (comb, zero when no hit)
//   irq_event_i                           interrupt set sources
//   ctrl_o, gp_o, irq_o                   register outputs (GP0 in gp_o LSBs)
module rif_csr_bank
    import rif_csr_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BYTE_COUNT = DATA_WIDTH / 8,
    parameter int                    NUM_IRQ    = 8,
    parameter int                    NUM_GP     = 4,
    parameter logic [31:0]           ID_VALUE   = 32'hC5B0_0001,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        rif_waddr,
    input  logic                         rif_wr_req,
    input  logic [BYTE_COUNT-1:0]        rif_wstrb,
    input  logic [DATA_WIDTH-1:0]        rif_wdata,
    output logic                         rif_wvalid,
    input  logic [ADDR_WIDTH-1:0]        rif_raddr,
    input  logic                         rif_rd_req,
    output logic                         rif_rvalid,
    output logic [DATA_WIDTH-1:0]        rif_rdata,
    input  logic [NUM_IRQ-1:0]           irq_event_i,
    output logic [DATA_WIDTH-1:0]        ctrl_o,
    output logic [NUM_GP*DATA_WIDTH-1:0] gp_o,
    output logic                         irq_o
);

    if (DATA_WIDTH != 32) begin : g_dw_check
        $fatal(1, "rif_csr_bank: DATA_WIDTH must be 32");
    end
    if (NUM_IRQ < 1 || NUM_IRQ > DATA_WIDTH) begin : g_irq_check
        $fatal(1, "rif_csr_bank: NUM_IRQ must be 1..DATA_WIDTH");
    end

    localparam int GP_N = (NUM_GP > 0) ? NUM_GP : 1;

    function automatic acc_e decode(input logic [31:0] idx);
        acc_e a;
        a = ACC_NONE;
        if (idx == IDX_ID)                  a = ACC_RO;
        else if (idx == IDX_CTRL)           a = ACC_RW;
        else if (idx == IDX_IRQ_STATUS)     a = ACC_W1C;
        else if (idx == IDX_IRQ_ENABLE)     a = ACC_RW;
        else if (idx == IDX_IRQ_FORCE)      a = ACC_WO;
`ifdef RIF_CSR_CYCLE_COUNTER_EN
        else if (idx == IDX_CYCLE)          a = ACC_RO;
`endif
        else if (idx >= IDX_GP_BASE && idx < IDX_GP_BASE + NUM_GP) a = ACC_RW;
        return a;
    endfunction

    logic [31:0]           widx, ridx;
    acc_e                  wacc, racc;
    logic [DATA_WIDTH-1:0] wmask, wbits;
    logic [DATA_WIDTH-1:0] ctrl_q;
    logic [DATA_WIDTH-1:0] gp_q [GP_N];
    logic [NUM_IRQ-1:0]    status, enable;
    logic                  unused_addr_bits;

    assign widx = 32'(rif_waddr[ADDR_WIDTH-1:2]);
    assign ridx = 32'(rif_raddr[ADDR_WIDTH-1:2]);
    assign unused_addr_bits = ^{rif_waddr[1:0], rif_raddr[1:0]};

    assign wacc  = decode(widx);
    assign racc  = decode(ridx);
    assign wmask = strb_to_mask(rif_wstrb);
    assign wbits = rif_wdata & wmask;

    // RO entries are mapped for reads only; a zero strobe still counts as a valid write.
    assign rif_wvalid = rif_wr_req && (wacc == ACC_RW || wacc == ACC_W1C || wacc == ACC_WO);
    assign rif_rvalid = rif_rd_req && (racc != ACC_NONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= CTRL_RESET;
            for (int i = 0; i < GP_N; i++) gp_q[i] <= '0;
        end else if (rif_wvalid) begin
            if (widx == IDX_CTRL) ctrl_q <= (ctrl_q & ~wmask) | wbits;
            for (int i = 0; i < NUM_GP; i++) begin
                if (widx == IDX_GP_BASE + i) gp_q[i] <= (gp_q[i] & ~wmask) | wbits;
            end
        end
    end

`ifdef RIF_CSR_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end
`endif

    rif_csr_irq #(.NUM_IRQ(NUM_IRQ)) u_irq (
        .clk         (clk),
        .reset       (reset),
        .status_wr   (rif_wvalid && widx == IDX_IRQ_STATUS),
        .enable_wr   (rif_wvalid && widx == IDX_IRQ_ENABLE),
        .force_wr    (rif_wvalid && widx == IDX_IRQ_FORCE),
        .wbits       (wbits[NUM_IRQ-1:0]),
        .wmask_bits  (wmask[NUM_IRQ-1:0]),
        .irq_event_i (irq_event_i),
        .status_o    (status),
        .enable_o    (enable),
        .irq_o       (irq_o)
    );

    always_comb begin
        rif_rdata = '0;
        if (rif_rvalid) begin
            if (ridx == IDX_ID)              rif_rdata = ID_VALUE;
            else if (ridx == IDX_CTRL)       rif_rdata = ctrl_q;
            else if (ridx == IDX_IRQ_STATUS) rif_rdata[NUM_IRQ-1:0] = status;
            else if (ridx == IDX_IRQ_ENABLE) rif_rdata[NUM_IRQ-1:0] = enable;
`ifdef RIF_CSR_CYCLE_COUNTER_EN
            else if (ridx == IDX_CYCLE)      rif_rdata = cycle_q;
`endif
            for (int i = 0; i < NUM_GP; i++) begin
                if (ridx == IDX_GP_BASE + i) rif_rdata = gp_q[i];
            end
        end
    end

    assign ctrl_o = ctrl_q;

    if (NUM_GP > 0) begin : g_gp_out
        for (genvar g = 0; g < NUM_GP; g++) begin : g_gp
            assign gp_o[g*DATA_WIDTH +: DATA_WIDTH] = gp_q[g];
        end
    end

endmodule

// File: tb/tb_rif_csr_bank.sv
// tb/tb_rif_csr_bank.sv - randomized and directed bench for rif_csr_bank against a register model
module tb_rif_csr_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [11:0]  waddr, raddr;
    logic         wr_req, rd_req;
    logic [3:0]   wstrb;
    logic [31:0]  wdata;
    logic         wvalid, rvalid;
    logic [31:0]  rdata;
    logic [7:0]   irq_event;
    logic [31:0]  ctrl_o;
    logic [127:0] gp_o;
    logic         irq_o;

    always #5 clk = ~clk;

    rif_csr_bank dut (
        .clk         (clk),
        .reset       (reset),
        .rif_waddr   (waddr),
        .rif_wr_req  (wr_req),
        .rif_wstrb   (wstrb),
        .rif_wdata   (wdata),
        .rif_wvalid  (wvalid),
        .rif_raddr   (raddr),
        .rif_rd_req  (rd_req),
        .rif_rvalid  (rvalid),
        .rif_rdata   (rdata),
        .irq_event_i (irq_event),
        .ctrl_o      (ctrl_o),
        .gp_o        (gp_o),
        .irq_o       (irq_o)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register model: plain values updated with the map's access rules on each clock edge.
    logic [31:0] m_ctrl, m_gp [4], m_cyc;
    logic [7:0]  m_status, m_enable;
    logic        m_irq;
    logic [31:0] mt_msk, mt_wb;
    logic [7:0]  mt_clr, mt_set;
    int          mt_idx;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ctrl = 0; m_status = 0; m_enable = 0; m_irq = 0; m_cyc = 0;
            for (int i = 0; i < 4; i++) m_gp[i] = 0;
        end else begin
            mt_clr = 0;
            mt_set = 0;
            m_irq = |(m_status & m_enable);
            if (wr_req) begin
                mt_idx = int'(waddr[11:2]);
                for (int b = 0; b < 4; b++) mt_msk[8*b +: 8] = wstrb[b] ? 8'hFF : 8'h00;
                mt_wb = wdata & mt_msk;
                case (mt_idx)
                    1: m_ctrl = (m_ctrl & ~mt_msk) | mt_wb;
                    2: mt_clr = mt_wb[7:0];
                    3: m_enable = (m_enable & ~mt_msk[7:0]) | mt_wb[7:0];
                    4: mt_set = mt_wb[7:0];
                    8, 9, 10, 11: m_gp[mt_idx-8] = (m_gp[mt_idx-8] & ~mt_msk) | mt_wb;
                    default: ;
                endcase
            end
            m_status = (m_status & ~mt_clr) | irq_event | mt_set;
            m_cyc = m_cyc + 1;
        end
    end

    function automatic void exp_rd(input logic [11:0] a, input logic req,
                                   output logic v, output logic [31:0] d);
        int idx;
        idx = int'(a[11:2]);
        v = 0;
        d = 0;
        case (idx)
            0: begin v = 1; d = 32'hC5B0_0001; end
            1: begin v = 1; d = m_ctrl; end
            2: begin v = 1; d = {24'h0, m_status}; end
            3: begin v = 1; d = {24'h0, m_enable}; end
            4: v = 1;
`ifdef RIF_CSR_CYCLE_COUNTER_EN
            5: begin v = 1; d = m_cyc; end
`endif
            8, 9, 10, 11: begin v = 1; d = m_gp[idx-8]; end
            default: ;
        endcase
        if (!req) begin
            v = 0;
            d = 0;
        end
    endfunction

    function automatic logic exp_wv(input logic [11:0] a, input logic req);
        int idx;
        idx = int'(a[11:2]);
        return req && (idx inside {1, 2, 3, 4, 8, 9, 10, 11});
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        ev;
        logic [31:0] ed;
        if (chk_en) begin
            exp_rd(raddr, rd_req, ev, ed);
            chk("rvalid", rvalid, ev);
            chk("rdata", rdata, ed);
            chk("wvalid", wvalid, exp_wv(waddr, wr_req));
            chk("ctrl_o", ctrl_o, m_ctrl);
            chk("gp_o", gp_o, {m_gp[3], m_gp[2], m_gp[1], m_gp[0]});
            chk("irq_o", irq_o, m_irq);
        end
    end

    task automatic wr(input logic [11:0] a, input logic [3:0] s, input logic [31:0] d);
        wr_req = 1; waddr = a; wstrb = s; wdata = d;
        @(posedge clk); #1;
        wr_req = 0;
    endtask

    task automatic rd_now(input logic [11:0] a);
        rd_req = 1; raddr = a; #1;
    endtask

    logic [31:0] v1, v2;

    initial begin
        reset = 1; waddr = 0; raddr = 0; wr_req = 0; rd_req = 0;
        wstrb = 0; wdata = 0; irq_event = 0;
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;

        // Reset values and address decode.
        rd_now(12'h000); chk("id_rdata", rdata, 32'hC5B0_0001); chk("id_rvalid", rvalid, 1'b1);
        rd_now(12'h004); chk("ctrl_reset", rdata, 32'h0);       chk("ctrl_rvalid", rvalid, 1'b1);
        rd_now(12'h00C); chk("enable_reset", rdata, 32'h0);     chk("enable_rvalid", rvalid, 1'b1);
        rd_now(12'h0FC); chk("unmapped_rvalid", rvalid, 1'b0);  chk("unmapped_rdata", rdata, 32'h0);
        rd_req = 0;
        @(posedge clk); #1;

        // Byte-masked CTRL writes.
        wr(12'h004, 4'hF, 32'hAABB_CCDD);
        wr(12'h004, 4'h5, 32'h1122_3344);
        chk("ctrl_masked", ctrl_o, 32'hAA22_CC44);
        wr_req = 1; waddr = 12'h004; wstrb = 4'h0; wdata = 32'hFFFF_FFFF; #1;
        chk("zero_strb_wvalid", wvalid, 1'b1);
        @(posedge clk); #1; wr_req = 0;
        chk("zero_strb_ctrl", ctrl_o, 32'hAA22_CC44);

        // Interrupt timing: event, status, irq two edges later, W1C drops it one edge later.
        wr(12'h00C, 4'hF, 32'h08);
        irq_event = 8'h08;
        @(posedge clk); #1; irq_event = 0;
        chk("irq_after_1", irq_o, 1'b0);
        rd_now(12'h008); chk("status_set", rdata, 32'h08); rd_req = 0;
        @(posedge clk); #1;
        chk("irq_after_2", irq_o, 1'b1);
        wr(12'h008, 4'hF, 32'h08);
        chk("irq_hold_after_w1c", irq_o, 1'b1);
        @(posedge clk); #1;
        chk("irq_low_after_w1c", irq_o, 1'b0);

        // Event beats W1C on the same edge; FORCE sets, reads 0.
        irq_event = 8'h08;
        wr(12'h008, 4'hF, 32'h08);
        irq_event = 0;
        rd_now(12'h008); chk("set_beats_clear", rdata, 32'h08); rd_req = 0;
        wr(12'h010, 4'hF, 32'h81);
        rd_now(12'h008); chk("force_status", rdata, 32'h89);
        rd_now(12'h010); chk("force_reads0", rdata, 32'h0); chk("force_rvalid", rvalid, 1'b1);
        rd_req = 0;

        // ID is read-only.
        wr_req = 1; waddr = 12'h000; wstrb = 4'hF; wdata = 32'h0; #1;
        chk("id_wvalid", wvalid, 1'b0);
        @(posedge clk); #1; wr_req = 0;
        rd_now(12'h000); chk("id_unchanged", rdata, 32'hC5B0_0001); rd_req = 0;

        // Reset in the middle of a GP write burst.
        wr(12'h020, 4'hF, 32'h1);
        wr(12'h024, 4'hF, 32'h2);
        chk("irq_before_reset", irq_o, 1'b1);
        wr_req = 1; waddr = 12'h028; wstrb = 4'hF; wdata = 32'h3;
        #2 reset = 1;
        #1;
        chk("gp_async_reset", gp_o, 128'h0);
        chk("irq_async_reset", irq_o, 1'b0);
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1 wr_req = 0;
        chk("gp_after_reset", gp_o, 128'h0000_0000_0000_0003_0000_0000_0000_0000);

`ifdef RIF_CSR_CYCLE_COUNTER_EN
        rd_now(12'h014); chk("cycle_rvalid", rvalid, 1'b1); v1 = rdata;
        repeat (10) @(posedge clk);
        #1; v2 = rdata; rd_req = 0;
        chk("cycle_delta", v2 - v1, 32'd10);
        wr_req = 1; waddr = 12'h014; wstrb = 4'hF; wdata = 32'h0; #1;
        chk("cycle_wvalid", wvalid, 1'b0);
        @(posedge clk); #1; wr_req = 0;
`else
        rd_now(12'h014); chk("idx5_rvalid", rvalid, 1'b0); chk("idx5_rdata", rdata, 32'h0);
        rd_req = 0;
        v1 = 0; v2 = 0;
`endif

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            wr_req = 1'($urandom_range(0, 1));
            rd_req = 1'($urandom_range(0, 1));
            waddr = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                                                : {10'($urandom_range(0, 13)), 2'($urandom)};
            raddr = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                                                : {10'($urandom_range(0, 13)), 2'($urandom)};
            wstrb = 4'($urandom);
            wdata = $urandom;
            irq_event = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h0;
            reset = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        reset = 0; wr_req = 0; rd_req = 0;
        @(posedge clk); #1;
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
